// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - CSR port arbiter and trap-entry/mret sequencer (optional CSR_VECTORED_EN)
module csr_trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            core_req,
    input  logic            core_we,
    input  logic [1:0]      core_op,
    input  logic [11:0]     core_addr,
    input  logic [XLEN-1:0] core_wdata,
    output logic            core_gnt,
    output logic [XLEN-1:0] core_rdata,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_req,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            csr_en,
    output logic            csr_we,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    localparam logic [1:0] OP_RW = 2'b00;
    localparam logic [1:0] OP_RS = 2'b01;
    localparam logic [1:0] OP_RC = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        T_EPC,
        T_CAUSE,
        T_TVAL,
        T_STATUS,
        T_VEC,
        R_STATUS,
        R_EPC
    } state_t;

    state_t          state;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] tval_q;

    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] vec_target;

    // mstatus on trap entry: MPIE <- MIE, MIE <- 0, MPP <- M-mode
    function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // mstatus on mret: MIE <- MPIE, MPIE <- 1, MPP <- U-mode
    function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b00;
        return r;
    endfunction

    // Pipeline hold while a sequence is requested or running
    always_comb begin
        stall = trap_req | mret_req | (state != IDLE);
    end

    // Pipeline access only when idle and no sequence wants the port
    always_comb begin
        core_gnt = core_req & (state == IDLE) & ~trap_req & ~mret_req & ~rst;
    end

    // Trap target: direct base, or base + 4*cause for vectored interrupts
    always_comb begin
        vec_base = {csr_rdata[XLEN-1:2], 2'b00};
`ifdef CSR_VECTORED_EN
        if ((csr_rdata[1:0] == 2'b01) && cause_q[XLEN-1]) begin
            vec_target = vec_base + {cause_q[XLEN-3:0], 2'b00};
        end else begin
            vec_target = vec_base;
        end
`else
        vec_target = vec_base;
`endif
    end

    // CSR port mux: sequence states own the port, otherwise a granted core access
    always_comb begin
        csr_en     = 1'b0;
        csr_we     = 1'b0;
        csr_addr   = 12'h000;
        csr_wdata  = '0;
        core_rdata = '0;
        case (state)
            IDLE: begin
                if (core_gnt) begin
                    csr_en     = 1'b1;
                    csr_we     = core_we;
                    csr_addr   = core_addr;
                    core_rdata = csr_rdata;
                    case (core_op)
                        OP_RW:   csr_wdata = core_wdata;
                        OP_RS:   csr_wdata = csr_rdata | core_wdata;
                        OP_RC:   csr_wdata = csr_rdata & ~core_wdata;
                        default: csr_wdata = core_wdata;
                    endcase
                end
            end
            T_EPC: begin
                csr_en    = 1'b1;
                csr_we    = 1'b1;
                csr_addr  = ADDR_MEPC;
                csr_wdata = epc_q;
            end
            T_CAUSE: begin
                csr_en    = 1'b1;
                csr_we    = 1'b1;
                csr_addr  = ADDR_MCAUSE;
                csr_wdata = cause_q;
            end
            T_TVAL: begin
                csr_en    = 1'b1;
                csr_we    = 1'b1;
                csr_addr  = ADDR_MTVAL;
                csr_wdata = tval_q;
            end
            T_STATUS: begin
                csr_en    = 1'b1;
                csr_we    = 1'b1;
                csr_addr  = ADDR_MSTATUS;
                csr_wdata = trap_status(csr_rdata);
            end
            T_VEC: begin
                csr_en   = 1'b1;
                csr_addr = ADDR_MTVEC;
            end
            R_STATUS: begin
                csr_en    = 1'b1;
                csr_we    = 1'b1;
                csr_addr  = ADDR_MSTATUS;
                csr_wdata = mret_status(csr_rdata);
            end
            R_EPC: begin
                csr_en   = 1'b1;
                csr_addr = ADDR_MEPC;
            end
            default: begin
                csr_en = 1'b0;
            end
        endcase
        // A reset aborts the sequence without touching the CSR file again
        if (rst) begin
            csr_en = 1'b0;
            csr_we = 1'b0;
        end
    end

    // Sequencer: arbitration, operand latching, state walk and registered redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            epc_q          <= '0;
            cause_q        <= '0;
            tval_q         <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (trap_req) begin
                        epc_q   <= trap_pc & ~XLEN'(3);
                        cause_q <= trap_cause;
                        tval_q  <= trap_tval;
                        state   <= T_EPC;
                    end else if (mret_req) begin
                        state <= R_STATUS;
                    end
                end
                T_EPC:    state <= T_CAUSE;
                T_CAUSE:  state <= T_TVAL;
                T_TVAL:   state <= T_STATUS;
                T_STATUS: state <= T_VEC;
                T_VEC: begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= vec_target;
                    state          <= IDLE;
                end
                R_STATUS: state <= R_EPC;
                R_EPC: begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= csr_rdata;
                    state          <= IDLE;
                end
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb/tb_csr_trap_ctrl.sv - directed self-checking bench for csr_trap_ctrl
module tb_csr_trap_ctrl;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic        core_we;
    logic [1:0]  core_op;
    logic [11:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_gnt;
    logic [31:0] core_rdata;
    logic        trap_req;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic        mret_req;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        csr_en;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    int total;
    int bad;

`ifdef CSR_VECTORED_EN
    localparam logic [31:0] VEC_EXP = 32'h0000021C;
`else
    localparam logic [31:0] VEC_EXP = 32'h00000200;
`endif

    // Small CSR file model with a preload port
    logic [31:0] m_status, m_tvec, m_epc, m_cause, m_tval;
    logic        pre_en;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;

    csr_trap_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_op(core_op),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rdata(core_rdata),
        .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .mret_req(mret_req), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .csr_en(csr_en), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en || (csr_en && csr_we)) begin
            case (pre_en ? pre_addr : csr_addr)
                12'h300: m_status <= pre_en ? pre_data : csr_wdata;
                12'h305: m_tvec   <= pre_en ? pre_data : csr_wdata;
                12'h341: m_epc    <= pre_en ? pre_data : csr_wdata;
                12'h342: m_cause  <= pre_en ? pre_data : csr_wdata;
                12'h343: m_tval   <= pre_en ? pre_data : csr_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (csr_addr)
            12'h300: csr_rdata = m_status;
            12'h305: csr_rdata = m_tvec;
            12'h341: csr_rdata = m_epc;
            12'h342: csr_rdata = m_cause;
            12'h343: csr_rdata = m_tval;
            default: csr_rdata = 32'h0;
        endcase
    end

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; core_req = 1'b1; core_we = 1'b1; core_addr = 12'h300;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        total++; if (csr_en !== 1'b0) begin bad++; $display("FAIL rst_hold_csr_en: got %b want 0", csr_en); end
        @(posedge clk); #1;
        rst = 1'b0; core_req = 1'b0; core_we = 1'b0;
        @(negedge clk);
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL rst_redirect_valid: got %b want 0", redirect_valid); end
        total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL rst_redirect_pc: got %h want 0", redirect_pc); end
        total++; if (csr_en !== 1'b0 || csr_we !== 1'b0) begin bad++; $display("FAIL rst_csr_en_we: got %b%b want 00", csr_en, csr_we); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        total++; if (core_rdata !== 32'h0) begin bad++; $display("FAIL rst_core_rdata: got %h want 0", core_rdata); end
    endtask

    task automatic test_core_access;
        preload(12'h300, 32'h8);
        preload(12'h305, 32'h200);
        core_req = 1'b1; core_we = 1'b1; core_op = 2'b01; core_addr = 12'h300; core_wdata = 32'h80;
        @(negedge clk);
        total++; if (core_gnt !== 1'b1) begin bad++; $display("FAIL rs_gnt: got %b want 1", core_gnt); end
        total++; if (csr_wdata !== 32'h88) begin bad++; $display("FAIL rs_wdata: got %h want 88", csr_wdata); end
        total++; if (core_rdata !== 32'h8) begin bad++; $display("FAIL rs_rdata: got %h want 8", core_rdata); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rs_stall: got %b want 0", stall); end
        total++; if (csr_en !== 1'b1 || csr_we !== 1'b1 || csr_addr !== 12'h300) begin bad++; $display("FAIL rs_port: got en=%b we=%b addr=%h want 1 1 300", csr_en, csr_we, csr_addr); end
        @(posedge clk); #1;
        core_op = 2'b10; core_wdata = 32'h08;
        @(negedge clk);
        total++; if (core_rdata !== 32'h88) begin bad++; $display("FAIL rc_rdata: got %h want 88", core_rdata); end
        total++; if (csr_wdata !== 32'h80) begin bad++; $display("FAIL rc_wdata: got %h want 80", csr_wdata); end
        @(posedge clk); #1;
        core_op = 2'b00; core_we = 1'b0; core_addr = 12'h305; core_wdata = 32'h1234;
        @(negedge clk);
        total++; if (csr_we !== 1'b0 || csr_en !== 1'b1) begin bad++; $display("FAIL rd_only_port: got en=%b we=%b want 1 0", csr_en, csr_we); end
        total++; if (core_rdata !== 32'h200) begin bad++; $display("FAIL rd_only_rdata: got %h want 200", core_rdata); end
        @(posedge clk); #1;
        core_we = 1'b1; core_addr = 12'h343; core_wdata = 32'hCAFE0000;
        @(negedge clk);
        total++; if (csr_wdata !== 32'hCAFE0000) begin bad++; $display("FAIL rw_wdata: got %h want cafe0000", csr_wdata); end
        @(posedge clk); #1;
        core_req = 1'b0; core_we = 1'b0;
        @(negedge clk);
        total++; if (core_gnt !== 1'b0 || core_rdata !== 32'h0 || csr_en !== 1'b0) begin bad++; $display("FAIL no_req: got gnt=%b rdata=%h en=%b want 0 0 0", core_gnt, core_rdata, csr_en); end
        total++; if (m_status !== 32'h80 || m_tval !== 32'hCAFE0000) begin bad++; $display("FAIL core_writes: got mstatus=%h mtval=%h want 80 cafe0000", m_status, m_tval); end
    endtask

    task automatic test_trap_entry;
        logic [11:0] ea [1:5];
        logic        ew [1:5];
        logic [31:0] ed [1:5];
        ea = '{12'h341, 12'h342, 12'h343, 12'h300, 12'h305};
        ew = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ed = '{32'h104, 32'h2, 32'hDEADBEEF, 32'h1880, 32'h0};
        preload(12'h300, 32'h8);
        trap_req = 1'b1; trap_pc = 32'h106; trap_cause = 32'h2; trap_tval = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL trap_c0_stall: got %b want 1", stall); end
        @(posedge clk); #1;
        trap_req = 1'b0; trap_pc = 32'hFFFFFFFF; trap_cause = 32'h0; trap_tval = 32'h0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            total++;
            if (csr_en !== 1'b1 || csr_we !== ew[c] || csr_addr !== ea[c] || (ew[c] && csr_wdata !== ed[c])) begin
                bad++;
                $display("FAIL trap_c%0d_port: got en=%b we=%b addr=%h data=%h want 1 %b %h %h", c, csr_en, csr_we, csr_addr, csr_wdata, ew[c], ea[c], ed[c]);
            end
            total++; if (stall !== 1'b1 || redirect_valid !== 1'b0) begin bad++; $display("FAIL trap_c%0d_stall_rv: got %b%b want 10", c, stall, redirect_valid); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin bad++; $display("FAIL trap_c6_redirect: got v=%b pc=%h want 1 200", redirect_valid, redirect_pc); end
        total++; if (stall !== 1'b0 || csr_en !== 1'b0) begin bad++; $display("FAIL trap_c6_idle: got stall=%b en=%b want 0 0", stall, csr_en); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL trap_c7_rv: got %b want 0", redirect_valid); end
        total++; if (m_epc !== 32'h104 || m_cause !== 32'h2 || m_tval !== 32'hDEADBEEF || m_status !== 32'h1880) begin bad++; $display("FAIL trap_csrs: got %h %h %h %h want 104 2 deadbeef 1880", m_epc, m_cause, m_tval, m_status); end
    endtask

    task automatic test_mret;
        @(posedge clk); #1;
        mret_req = 1'b1;
        @(negedge clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mret_c0_stall: got %b want 1", stall); end
        @(posedge clk); #1;
        mret_req = 1'b0;
        @(negedge clk);
        total++; if (csr_we !== 1'b1 || csr_addr !== 12'h300 || csr_wdata !== 32'h88) begin bad++; $display("FAIL mret_c1_status: got we=%b addr=%h data=%h want 1 300 88", csr_we, csr_addr, csr_wdata); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (csr_en !== 1'b1 || csr_we !== 1'b0 || csr_addr !== 12'h341 || stall !== 1'b1) begin bad++; $display("FAIL mret_c2_epc: got en=%b we=%b addr=%h stall=%b want 1 0 341 1", csr_en, csr_we, csr_addr, stall); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104 || stall !== 1'b0) begin bad++; $display("FAIL mret_c3_redirect: got v=%b pc=%h stall=%b want 1 104 0", redirect_valid, redirect_pc, stall); end
        total++; if (m_status !== 32'h88) begin bad++; $display("FAIL mret_mstatus: got %h want 88", m_status); end
    endtask

    task automatic test_simultaneous;
        preload(12'h300, 32'h8);
        trap_req = 1'b1; mret_req = 1'b1; core_req = 1'b1; core_we = 1'b0; core_op = 2'b00; core_addr = 12'h342;
        trap_pc = 32'h200; trap_cause = 32'hB; trap_tval = 32'h0;
        @(negedge clk);
        total++; if (core_gnt !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL sim_c0: got gnt=%b stall=%b want 0 1", core_gnt, stall); end
        @(posedge clk); #1;
        trap_req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            total++; if (core_gnt !== 1'b0) begin bad++; $display("FAIL sim_c%0d_gnt: got %b want 0", c, core_gnt); end
            if (c == 4) begin
                total++; if (csr_addr !== 12'h300 || csr_wdata !== 32'h1880) begin bad++; $display("FAIL sim_c4_status: got addr=%h data=%h want 300 1880", csr_addr, csr_wdata); end
            end
            @(posedge clk); #1;
        end
        mret_req = 1'b0;
        @(negedge clk);
        total++; if (core_gnt !== 1'b1 || core_rdata !== 32'hB || redirect_valid !== 1'b1) begin bad++; $display("FAIL sim_c6: got gnt=%b rdata=%h rv=%b want 1 b 1", core_gnt, core_rdata, redirect_valid); end
        @(posedge clk); #1;
        core_req = 1'b0;
        @(negedge clk);
        total++; if (stall !== 1'b0 || m_status !== 32'h1880) begin bad++; $display("FAIL sim_no_mret: got stall=%b mstatus=%h want 0 1880", stall, m_status); end
    endtask

    task automatic test_reset_mid_trap;
        logic seen;
        preload(12'h343, 32'h11111111);
        trap_req = 1'b1; trap_pc = 32'h300; trap_cause = 32'h5; trap_tval = 32'h55;
        @(posedge clk); #1;
        trap_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (csr_we !== 1'b0 || csr_en !== 1'b0) begin bad++; $display("FAIL rmid_c3_port: got en=%b we=%b want 0 0", csr_en, csr_we); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (csr_en !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rmid_idle: got en=%b stall=%b want 0 0", csr_en, stall); end
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (redirect_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmid_redirect: got %b want 0", seen); end
        total++; if (m_tval !== 32'h11111111 || m_epc !== 32'h300 || m_cause !== 32'h5) begin bad++; $display("FAIL rmid_csrs: got tval=%h epc=%h cause=%h want 11111111 300 5", m_tval, m_epc, m_cause); end
    endtask

    task automatic test_vectored;
        logic [31:0] vc [0:1];
        logic [31:0] ve [0:1];
        logic        found;
        int          n;
        logic [31:0] got;
        vc = '{32'h80000007, 32'h2};
        ve = '{VEC_EXP, 32'h200};
        preload(12'h305, 32'h201);
        for (int v = 0; v < 2; v++) begin
            @(posedge clk); #1;
            trap_req = 1'b1; trap_pc = 32'h0; trap_cause = vc[v]; trap_tval = 32'h0;
            @(posedge clk); #1;
            trap_req = 1'b0;
            found = 1'b0; n = 0; got = 32'h0;
            for (int k = 1; k <= 12 && !found; k++) begin
                @(negedge clk);
                if (redirect_valid === 1'b1) begin
                    found = 1'b1; n = k; got = redirect_pc;
                end else begin
                    @(posedge clk); #1;
                end
            end
            total++;
            if (!found) begin
                bad++; $display("FAIL vec%0d_timeout: got no redirect want redirect in cycle 6", v);
            end else begin
                if (n != 6 || got !== ve[v]) begin bad++; $display("FAIL vec%0d_redirect: got cycle=%0d pc=%h want 6 %h", v, n, got, ve[v]); end
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_op = 2'b00; core_addr = 12'h0; core_wdata = 32'h0;
        trap_req = 1'b0; trap_pc = 32'h0; trap_cause = 32'h0; trap_tval = 32'h0; mret_req = 1'b0;
        pre_en = 1'b0; pre_addr = 12'h0; pre_data = 32'h0;
        test_reset;
        test_core_access;
        test_trap_entry;
        test_mret;
        test_simultaneous;
        test_reset_mid_trap;
        test_vectored;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
